vending_machine_gen: RTL and testbench
======================================

VENDING_MACHINE_GEN -- requirements
Module: vending_machine_gen

Interface
REQ-001 Parameter ITEM_W, default 4, item select width; NUM_ITEMS = 2**ITEM_W.
REQ-002 Parameter CREDIT_W, default 8, width of the credit and change registers.
REQ-003 Parameter PRICE_BASE, default 15, price of item 0 in cents.
REQ-004 Parameter PRICE_STEP, default 5, price increment per item index; price(i) = PRICE_BASE + i*PRICE_STEP.
REQ-005 Parameter STOCK_W, default 4, width of each per-item stock counter.
REQ-006 Parameter STOCK_INIT, default 5, stock loaded into every item on reset and restock.
REQ-007 PRICE_BASE, PRICE_STEP and price(NUM_ITEMS-1)+25 shall all be multiples of 5 and below 2**CREDIT_W; elaboration fails otherwise.
REQ-008 clock  in  1  single clock; all state updates on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 item_number  in  ITEM_W  item select, sampled only when the first coin is accepted in IDLE.
REQ-011 nickel_in  in  1  5-cent coin present this cycle.
REQ-012 dime_in  in  1  10-cent coin present this cycle.
REQ-013 quarter_in  in  1  25-cent coin present this cycle.
REQ-014 cancel  in  1  abort the purchase and refund the credit.
REQ-015 restock  in  1  reload all stock counters to STOCK_INIT.
REQ-016 dispense  out  1  one-cycle pulse; the latched item is delivered.
REQ-017 nickel_out  out  1  one 5-cent change coin this cycle.
REQ-018 dime_out  out  1  one 10-cent change coin this cycle.
REQ-019 coin_reject  out  1  one-cycle pulse; the coin(s) of the previous cycle were not credited.
REQ-020 credit  out  CREDIT_W  current accumulated credit in cents.
REQ-021 sold_out  out  1  combinational; stock of the item_number input is 0.
REQ-022 busy  out  1  high in DISPENSE and CHANGE.

Function
REQ-023 The FSM shall have states IDLE, COLLECT, DISPENSE and CHANGE.
REQ-024 A valid coin is exactly one of nickel_in, dime_in or quarter_in high in a cycle.
REQ-025 IDLE, valid coin, stock(item_number) > 0 -> latch item_number, credit = coin value, go to COLLECT (or go to DISPENSE if value >= price).
REQ-026 IDLE, valid coin, stock(item_number) == 0 -> no credit, coin_reject = 1 next cycle, stay in IDLE.
REQ-027 COLLECT, valid coin -> credit += value; if new credit >= price(latched item), go to DISPENSE.
REQ-028 More than one coin input high in any state, or any coin in DISPENSE/CHANGE -> nothing credited, coin_reject = 1 for the following cycle.
REQ-029 DISPENSE lasts exactly one cycle: dispense = 1, stock(latched item) decrements by 1, change = credit - price, credit = 0.
REQ-030 DISPENSE then goes to CHANGE if change > 0, else to IDLE.
REQ-031 COLLECT with cancel = 1 -> change = credit, credit = 0, go to CHANGE, no dispense.
REQ-032 cancel takes priority over a coin in the same cycle; that coin is rejected.
REQ-033 cancel in IDLE, DISPENSE or CHANGE is ignored.
REQ-034 CHANGE cycle: if change >= 10, dime_out = 1 and change -= 10; otherwise nickel_out = 1 and change -= 5.
REQ-035 In CHANGE, exit to IDLE in the cycle after change reaches 0; at most one change coin per cycle.
REQ-036 restock is honoured only in IDLE with no coin present in that cycle; otherwise it is ignored.
REQ-037 Stock counters never decrement below 0 (guaranteed by REQ-026).
REQ-038 dispense, nickel_out and dime_out are decoded from registered state and change; they are glitch-free and never high together.

Reset
REQ-039 While reset is high: state = IDLE, credit = 0, change = 0, all outputs 0 (sold_out 0), every stock counter = STOCK_INIT.
REQ-040 Reset asserted mid-purchase or mid-change discards the credit and the pending change without any further output pulses.

Verification
REQ-041 Item 4 (price 35): nickel, dime, quarter on successive cycles -> credit 5, 15; then dispense 1 cycle; nickel_out 1 cycle; IDLE; stock(4) = 4.
REQ-042 Item 0 (price 15): single quarter -> dispense 1 cycle, then dime_out 1 cycle, then IDLE, credit 0.
REQ-043 Item 4: nickel, dime, then cancel -> no dispense; dime_out 1 cycle, then nickel_out 1 cycle; credit 0.
REQ-044 nickel_in and dime_in high in the same cycle -> coin_reject 1 cycle, credit unchanged, state unchanged.
REQ-045 Buy item 0 five times -> sold_out = 1; a sixth coin is rejected; restock in IDLE -> sold_out = 0.
REQ-046 Reset asserted during CHANGE with 20 pending -> all outputs 0 immediately, state IDLE, no further coins emitted.

Source files
------------

// File: rtl/vending_machine_gen.sv
// Parameterised vending machine: per-item stock, coin credit, change payout.
// Ports:
//   clock, reset (async, active high)
//   item_number  : item select, latched on the first accepted coin
//   nickel_in, dime_in, quarter_in : coin inputs (exactly one = valid coin)
//   cancel       : refund credit while collecting
//   restock      : reload all stock counters (IDLE, no coin present)
//   dispense     : one-cycle delivery pulse
//   nickel_out, dime_out : one change coin per cycle
//   coin_reject  : last cycle's coin(s) were not credited
//   credit       : accumulated credit in cents
//   sold_out     : stock of item_number is zero
//   busy         : dispensing or paying change
module vending_machine_gen #(
  parameter int ITEM_W     = 4,
  parameter int CREDIT_W   = 8,
  parameter int PRICE_BASE = 15,
  parameter int PRICE_STEP = 5,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ITEM_W-1:0]   item_number,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                cancel,
  input  logic                restock,
  output logic                dispense,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                sold_out,
  output logic                busy
);

  localparam int NUM_ITEMS = 2 ** ITEM_W;
  localparam int PRICE_MAX = PRICE_BASE + (NUM_ITEMS - 1) * PRICE_STEP;
  localparam int CREDIT_LIM = 2 ** CREDIT_W;

  // Worst-case credit is just under the top price plus one quarter.
  if ((PRICE_BASE % 5 != 0) || (PRICE_STEP % 5 != 0) ||
      ((PRICE_MAX + 25) % 5 != 0) ||
      (PRICE_BASE >= CREDIT_LIM) || (PRICE_STEP >= CREDIT_LIM) ||
      (PRICE_MAX + 25 >= CREDIT_LIM)) begin : g_bad_params
    $error("vending_machine_gen: illegal price parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  function automatic logic [CREDIT_W-1:0] price_of(
    input logic [ITEM_W-1:0] idx
  );
    int p;
    p = PRICE_BASE + int'(idx) * PRICE_STEP;
    return p[CREDIT_W-1:0];
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CREDIT_W-1:0]  r_credit;
  logic [CREDIT_W-1:0]  w_credit_nxt;
  logic [CREDIT_W-1:0]  r_change;
  logic [CREDIT_W-1:0]  w_change_nxt;
  logic [ITEM_W-1:0]    r_item;
  logic [ITEM_W-1:0]    w_item_nxt;
  logic                 r_reject;
  logic                 w_reject_nxt;
  logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];

  logic [2:0]           w_coins;
  logic                 w_any;
  logic                 w_valid;
  logic                 w_multi;
  logic [CREDIT_W-1:0]  w_value;
  logic [CREDIT_W-1:0]  w_sum;
  logic [CREDIT_W-1:0]  w_pay;
  logic [STOCK_W-1:0]   w_sel_stock;
  logic                 w_dec;
  logic                 w_restock;

  assign w_coins     = {quarter_in, dime_in, nickel_in};
  assign w_any       = |w_coins;
  assign w_valid     = $onehot(w_coins);
  assign w_multi     = w_any & ~w_valid;
  assign w_sum       = r_credit + w_value;
  assign w_sel_stock = r_stock[item_number];
  assign w_pay       = (r_change >= CREDIT_W'(10)) ?
                       CREDIT_W'(10) : CREDIT_W'(5);

  always_comb begin
    w_value = '0;
    case (w_coins)
      3'b001:  w_value = CREDIT_W'(5);
      3'b010:  w_value = CREDIT_W'(10);
      3'b100:  w_value = CREDIT_W'(25);
      default: w_value = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_change <= '0;
      r_item   <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_change <= w_change_nxt;
      r_item   <= w_item_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_change_nxt = r_change;
    w_item_nxt   = r_item;
    w_reject_nxt = 1'b0;
    w_dec        = 1'b0;
    w_restock    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_multi) begin
          w_reject_nxt = 1'b1;
        end else if (w_valid) begin
          if (w_sel_stock == '0) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_item_nxt   = item_number;
            w_credit_nxt = w_value;
            if (w_value >= price_of(item_number))
              w_state_nxt = S_DISPENSE;
            else
              w_state_nxt = S_COLLECT;
          end
        end else if (restock) begin
          w_restock = 1'b1;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          // Any coin alongside cancel is bounced, not refunded.
          w_change_nxt = r_credit;
          w_credit_nxt = '0;
          w_state_nxt  = S_CHANGE;
          w_reject_nxt = w_any;
        end else if (w_multi) begin
          w_reject_nxt = 1'b1;
        end else if (w_valid) begin
          w_credit_nxt = w_sum;
          if (w_sum >= price_of(r_item))
            w_state_nxt = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        w_reject_nxt = w_any;
        w_dec        = 1'b1;
        w_change_nxt = r_credit - price_of(r_item);
        w_credit_nxt = '0;
        if (r_credit != price_of(r_item))
          w_state_nxt = S_CHANGE;
        else
          w_state_nxt = S_IDLE;
      end
      S_CHANGE: begin
        w_reject_nxt = w_any;
        if (r_change <= w_pay) begin
          w_change_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_change_nxt = r_change - w_pay;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (w_restock) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (w_dec) begin
      r_stock[r_item] <= r_stock[r_item] - STOCK_W'(1);
    end
  end

  // Pulses come straight from registers, so they cannot glitch.
  assign dispense    = (r_state == S_DISPENSE);
  assign dime_out    = (r_state == S_CHANGE) &&
                       (r_change >= CREDIT_W'(10));
  assign nickel_out  = (r_state == S_CHANGE) &&
                       (r_change != '0) &&
                       (r_change < CREDIT_W'(10));
  assign coin_reject = r_reject;
  assign credit      = r_credit;
  assign busy        = (r_state == S_DISPENSE) ||
                       (r_state == S_CHANGE);
  assign sold_out    = ~reset & (w_sel_stock == '0);

endmodule

// File: tb/tb_vending_machine_gen.sv
// Scoreboard bench for vending_machine_gen: directed purchases,
// cancels, rejects, sold-out/restock and reset during change.
module tb_vending_machine_gen;

  logic       clock;
  logic       reset;
  logic [3:0] item_number;
  logic       nickel_in;
  logic       dime_in;
  logic       quarter_in;
  logic       cancel;
  logic       restock;
  logic       dispense;
  logic       nickel_out;
  logic       dime_out;
  logic       coin_reject;
  logic [7:0] credit;
  logic       sold_out;
  logic       busy;

  vending_machine_gen dut (
    .clock       (clock),
    .reset       (reset),
    .item_number (item_number),
    .nickel_in   (nickel_in),
    .dime_in     (dime_in),
    .quarter_in  (quarter_in),
    .cancel      (cancel),
    .restock     (restock),
    .dispense    (dispense),
    .nickel_out  (nickel_out),
    .dime_out    (dime_out),
    .coin_reject (coin_reject),
    .credit      (credit),
    .sold_out    (sold_out),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] ev;
    logic [7:0] cr;
  } exp_t;

  localparam logic [3:0] DISP = 4'b1000;
  localparam logic [3:0] NICK = 4'b0100;
  localparam logic [3:0] DIME = 4'b0010;
  localparam logic [3:0] REJ  = 4'b0001;

  localparam logic [2:0] C_N = 3'b001;
  localparam logic [2:0] C_D = 3'b010;
  localparam logic [2:0] C_Q = 3'b100;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input logic [3:0] ev, input logic [7:0] cr);
    exp_t e;
    e.ev = ev;
    e.cr = cr;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic can,
                      input logic rs, input logic [3:0] it);
    {quarter_in, dime_in, nickel_in} = c;
    cancel      = can;
    restock     = rs;
    item_number = it;
    @(posedge clock);
    #1;
    {quarter_in, dime_in, nickel_in} = 3'b000;
    cancel  = 1'b0;
    restock = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every output event must match the head of the queue.
  always @(negedge clock) begin
    logic [3:0] ev;
    exp_t e;
    ev = {dispense, nickel_out, dime_out, coin_reject};
    if (!reset && ev != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got ev=%b credit=%0d, none expected",
                 ev, credit);
      end else begin
        e = exp_q.pop_front();
        if (ev != e.ev || credit != e.cr) begin
          errors++;
          $display("FAIL event: got ev=%b credit=%0d expected ev=%b credit=%0d",
                   ev, credit, e.ev, e.cr);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    item_number = 4'd0;
    nickel_in   = 1'b0;
    dime_in     = 1'b0;
    quarter_in  = 1'b0;
    cancel      = 1'b0;
    restock     = 1'b0;
    idle(2);
    chk("rst_outputs", int'({dispense, nickel_out, dime_out, coin_reject}), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sold_out", int'(sold_out), 0);
    reset = 1'b0;
    idle(1);
    chk("idle_credit", int'(credit), 0);

    // Five quarters for item 0 (15c): dispense then one dime each.
    for (int k = 0; k < 5; k++) begin
      push(DISP, 8'd25);
      push(DIME, 8'd0);
      step(C_Q, 1'b0, 1'b0, 4'd0);
      if (k == 0) chk("buy0_busy", int'(busy), 1);
      idle(3);
    end
    chk("sold_out_item0", int'(sold_out), 1);
    item_number = 4'd1;
    #1;
    chk("sold_out_item1", int'(sold_out), 0);
    item_number = 4'd0;
    push(REJ, 8'd0);
    step(C_Q, 1'b0, 1'b0, 4'd0);
    chk("sixth_credit", int'(credit), 0);
    idle(2);
    push(REJ, 8'd0);
    step(C_N, 1'b0, 1'b1, 4'd0);
    idle(1);
    chk("restock_with_coin", int'(sold_out), 1);
    step(3'b000, 1'b0, 1'b1, 4'd0);
    chk("restock_idle", int'(sold_out), 0);

    // Item 4 (35c): 5 + 10 + 25 = 40, one nickel back.
    step(C_N, 1'b0, 1'b0, 4'd4);
    chk("i4_credit_5", int'(credit), 5);
    step(C_D, 1'b0, 1'b0, 4'd4);
    chk("i4_credit_15", int'(credit), 15);
    push(DISP, 8'd40);
    push(NICK, 8'd0);
    step(C_Q, 1'b0, 1'b0, 4'd4);
    chk("i4_busy", int'(busy), 1);
    idle(3);
    chk("i4_done_credit", int'(credit), 0);
    chk("i4_done_busy", int'(busy), 0);

    // Item 0 quarter; a nickel dropped during DISPENSE is bounced.
    push(DISP, 8'd25);
    push(DIME | REJ, 8'd0);
    step(C_Q, 1'b0, 1'b0, 4'd0);
    step(C_N, 1'b0, 1'b0, 4'd0);
    idle(3);
    chk("i0_done_credit", int'(credit), 0);

    // Cancel with 15c: dime then nickel refunded.
    step(C_N, 1'b0, 1'b0, 4'd4);
    step(C_D, 1'b0, 1'b0, 4'd4);
    push(DIME, 8'd0);
    push(NICK, 8'd0);
    step(3'b000, 1'b1, 1'b0, 4'd4);
    chk("cancel_credit", int'(credit), 0);
    chk("cancel_busy", int'(busy), 1);
    idle(3);
    chk("cancel_done_busy", int'(busy), 0);
    step(3'b000, 1'b1, 1'b0, 4'd4);
    chk("cancel_in_idle", int'(busy), 0);

    // Two coins at once while collecting.
    step(C_N, 1'b0, 1'b0, 4'd4);
    push(REJ, 8'd5);
    step(C_N | C_D, 1'b0, 1'b0, 4'd4);
    chk("multi_credit", int'(credit), 5);
    chk("multi_busy", int'(busy), 0);
    // Cancel beats a coin in the same cycle.
    push(NICK | REJ, 8'd0);
    step(C_D, 1'b1, 1'b0, 4'd4);
    chk("cancel_coin_credit", int'(credit), 0);
    idle(3);
    push(REJ, 8'd0);
    step(C_N | C_D | C_Q, 1'b0, 1'b0, 4'd4);
    chk("multi_idle_credit", int'(credit), 0);
    idle(2);

    // Exact payment for item 1 (20c): no change, straight to IDLE.
    step(C_D, 1'b0, 1'b0, 4'd1);
    push(DISP, 8'd20);
    step(C_D, 1'b0, 1'b0, 4'd1);
    chk("exact_busy", int'(busy), 1);
    idle(1);
    chk("exact_done_busy", int'(busy), 0);

    // Reset while 20c change is pending.
    step(C_D, 1'b0, 1'b0, 4'd4);
    step(C_D, 1'b0, 1'b0, 4'd4);
    step(3'b000, 1'b1, 1'b0, 4'd4);
    reset = 1'b1;
    #1;
    chk("rst_chg_outputs",
        int'({dispense, nickel_out, dime_out, coin_reject}), 0);
    chk("rst_chg_busy", int'(busy), 0);
    chk("rst_chg_credit", int'(credit), 0);
    idle(2);
    reset = 1'b0;
    idle(6);
    chk("after_rst_busy", int'(busy), 0);

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
